// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcode values, field positions, sign-extend helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package dlx_pkg;

    // Primary opcodes that can transfer control.
    localparam logic [5:0] J    = 6'h02;
    localparam logic [5:0] JAL  = 6'h03;
    localparam logic [5:0] BEQZ = 6'h04;
    localparam logic [5:0] BNEZ = 6'h05;
    localparam logic [5:0] BFPT = 6'h06;
    localparam logic [5:0] BFPF = 6'h07;
    localparam logic [5:0] RFE  = 6'h10;
    localparam logic [5:0] TRAP = 6'h11;
    localparam logic [5:0] JR   = 6'h12;
    localparam logic [5:0] JALR = 6'h13;

    // Field positions in the big-endian-numbered instruction word (bit 0 = MSB).
    localparam int OPCODE_FIRST = 0;
    localparam int OPCODE_LAST  = 5;
    localparam int RS1_FIRST    = 6;
    localparam int RS1_LAST     = 10;
    localparam int IMM16_FIRST  = 16;
    localparam int IMM16_LAST   = 31;
    localparam int OFF26_FIRST  = 6;
    localparam int OFF26_LAST   = 31;

    // Which source the next-PC mux selects.
    typedef enum logic [2:0] {
        SEL_SEQ,    // pc_plus_four (fall-through)
        SEL_REL16,  // pc_plus_four + sext(imm16)
        SEL_REL26,  // pc_plus_four + sext(offset26)
        SEL_REG,    // rs1
        SEL_ABS26,  // zero-extended offset26
        SEL_IAR     // saved interrupt address
    } target_sel_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

endpackage

// File: rtl/jump_branch_target.sv
// Next-PC adder and mux driven by the decode select.
// Latency: purely combinational.
// Backpressure: none.
// Ports: sel (target select), offset26 (instruction bits 6..31, imm16 is its low half),
//        pc_plus_four, rs1, iar -> next_pc.
module jump_branch_target
    import dlx_pkg::*;
(
    input  target_sel_t  sel,
    input  logic [25:0]  offset26,
    input  logic [31:0]  pc_plus_four,
    input  logic [31:0]  rs1,
    input  logic [31:0]  iar,
    output logic [31:0]  next_pc
);

    // Both relative forms share one base; additions wrap modulo 2^32.
    logic [31:0] rel16;
    logic [31:0] rel26;

    assign rel16 = pc_plus_four + sext16(offset26[15:0]);
    assign rel26 = pc_plus_four + sext26(offset26);

    always_comb begin
        next_pc = pc_plus_four;
        case (sel)
            SEL_SEQ:   next_pc = pc_plus_four;
            SEL_REL16: next_pc = rel16;
            SEL_REL26: next_pc = rel26;
            SEL_REG:   next_pc = rs1;
            SEL_ABS26: next_pc = {6'b0, offset26};
            SEL_IAR:   next_pc = iar;
            default:   next_pc = pc_plus_four;
        endcase
    end

endmodule

// File: rtl/jump_branch.sv
// DLX decode-stage jump/branch resolver: takeBranch/outputPC plus registered link (R31) value.
// Latency: outputPC/takeBranch combinational; register31 (and IAR) update on the rising clk edge.
// Backpressure: none; kill/stall qualification is done by the caller.
// Ports: clk, reset (async, active-high), instruction[0:31] (bit 0 = MSB), pc_plus_four, rs1
//        -> outputPC, takeBranch, register31.
// Optional: define JUMP_BRANCH_TRAP_RFE_EN to add TRAP/RFE and the internal IAR register.
module jump_branch
    import dlx_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] LINK_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:31]      instruction,
    input  logic [WIDTH-1:0] pc_plus_four,
    input  logic [WIDTH-1:0] rs1,
    output logic [WIDTH-1:0] outputPC,
    output logic             takeBranch,
    output logic [WIDTH-1:0] register31
);

    logic [5:0]  opcode;
    logic [25:0] offset26;
    logic        rs1_zero;

    assign opcode   = instruction[OPCODE_FIRST:OPCODE_LAST];
    assign offset26 = instruction[OFF26_FIRST:OFF26_LAST];
    assign rs1_zero = (rs1 == '0);

    target_sel_t sel;
    logic        take;
    logic        link;
    logic        trap;

    // The select is forced to SEL_SEQ whenever nothing is taken, so outputPC
    // falls through to pc_plus_four without a separate qualifying mux.
    always_comb begin
        sel  = SEL_SEQ;
        take = 1'b0;
        link = 1'b0;
        trap = 1'b0;
        case (opcode)
            J: begin
                sel  = SEL_REL26;
                take = 1'b1;
            end
            JAL: begin
                sel  = SEL_REL26;
                take = 1'b1;
                link = 1'b1;
            end
            BEQZ: begin
                take = rs1_zero;
                sel  = rs1_zero ? SEL_REL16 : SEL_SEQ;
            end
            BNEZ: begin
                take = !rs1_zero;
                sel  = rs1_zero ? SEL_SEQ : SEL_REL16;
            end
            JR: begin
                sel  = SEL_REG;
                take = 1'b1;
            end
            JALR: begin
                sel  = SEL_REG;
                take = 1'b1;
                link = 1'b1;
            end
            // No FP condition flag exists in this core: FP branches never taken.
            BFPT, BFPF: begin
            end
`ifdef JUMP_BRANCH_TRAP_RFE_EN
            TRAP: begin
                sel  = SEL_ABS26;
                take = 1'b1;
                trap = 1'b1;
            end
            RFE: begin
                sel  = SEL_IAR;
                take = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    logic [31:0] iar;

`ifdef JUMP_BRANCH_TRAP_RFE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iar <= '0;
        end else if (trap) begin
            iar <= pc_plus_four;
        end
    end
`else
    assign iar = '0;
`endif

    // No delay slot, so the return address is the next sequential PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            register31 <= LINK_RESET;
        end else if (link) begin
            register31 <= pc_plus_four;
        end
    end

    assign takeBranch = take;

    jump_branch_target u_target (
        .sel          (sel),
        .offset26     (offset26),
        .pc_plus_four (pc_plus_four),
        .rs1          (rs1),
        .iar          (iar),
        .next_pc      (outputPC)
    );

endmodule

// File: tb/tb_jump_branch.sv
// Self-checking bench for jump_branch: combinational vector table plus link/IAR/reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_jump_branch;

    logic        clk;
    logic        reset;
    logic [0:31] instruction;
    logic [31:0] pc_plus_four;
    logic [31:0] rs1;
    logic [31:0] outputPC;
    logic        takeBranch;
    logic [31:0] register31;

    int checks = 0;
    int errors = 0;

    jump_branch dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .pc_plus_four (pc_plus_four),
        .rs1          (rs1),
        .outputPC     (outputPC),
        .takeBranch   (takeBranch),
        .register31   (register31)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [25:0] low;
        logic [31:0] pc4;
        logic [31:0] r1;
        logic        take;
        logic [31:0] npc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [25:0] low,
                         input logic [31:0] pc4, input logic [31:0] r1);
        instruction  = {op, low};
        pc_plus_four = pc4;
        rs1          = r1;
    endtask

    initial begin
        // name, opcode, offset26 field, pc_plus_four, rs1, takeBranch, outputPC
        vecs.push_back('{"beqz_taken",    6'h04, 26'h0000010, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0110});
        vecs.push_back('{"beqz_not",      6'h04, 26'h0000010, 32'h0000_0100, 32'h5,         1'b0, 32'h0000_0100});
        vecs.push_back('{"bnez_neg",      6'h05, 26'h000FFF0, 32'h0000_0200, 32'h1,         1'b1, 32'h0000_01F0});
        vecs.push_back('{"bnez_not",      6'h05, 26'h000FFF0, 32'h0000_0200, 32'h0,         1'b0, 32'h0000_0200});
        vecs.push_back('{"beqz_hi_bits",  6'h04, 26'h3FF0010, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0110});
        vecs.push_back('{"beqz_min_imm",  6'h04, 26'h0008000, 32'h0001_0000, 32'h0,         1'b1, 32'h0000_8000});
        vecs.push_back('{"j_fwd",         6'h02, 26'h0000040, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_1040});
        vecs.push_back('{"j_neg",         6'h02, 26'h3FFFFF8, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_00F8});
        vecs.push_back('{"j_wrap",        6'h02, 26'h0000008, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0004});
        vecs.push_back('{"jr_unaligned",  6'h12, 26'h0000000, 32'h0000_0300, 32'hDEAD_BEE1, 1'b1, 32'hDEAD_BEE1});
        vecs.push_back('{"add_rtype",     6'h00, 26'h0000020, 32'h0000_0500, 32'h0,         1'b0, 32'h0000_0500});
        vecs.push_back('{"rtype_01",      6'h01, 26'h3FFFFFF, 32'h0000_0504, 32'h0,         1'b0, 32'h0000_0504});
        vecs.push_back('{"bfpt",          6'h06, 26'h0000010, 32'h0000_0600, 32'h0,         1'b0, 32'h0000_0600});
        vecs.push_back('{"bfpf",          6'h07, 26'h0000010, 32'h0000_0700, 32'h0,         1'b0, 32'h0000_0700});
        vecs.push_back('{"lw_other",      6'h23, 26'h0000010, 32'h0000_0800, 32'h0,         1'b0, 32'h0000_0800});

        reset = 1'b1;
        drive(6'h00, 26'h0, 32'h0000_0040, 32'h0);
        #3;
        check("reset_r31", register31, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        // Combinational table, changed and sampled mid-low-phase.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].low, vecs[i].pc4, vecs[i].r1);
            #1;
            check({vecs[i].name, "_take"}, {31'b0, takeBranch}, {31'b0, vecs[i].take});
            check({vecs[i].name, "_pc"}, outputPC, vecs[i].npc);
        end
        check("r31_untouched", register31, 32'h0000_0000);

        // JAL: link captured at the edge, then held through an ADD.
        @(negedge clk);
        drive(6'h03, 26'h0000040, 32'h0000_1000, 32'h0);
        #1;
        check("jal_take", {31'b0, takeBranch}, 32'h1);
        check("jal_pc", outputPC, 32'h0000_1040);
        @(posedge clk); #1;
        check("jal_r31", register31, 32'h0000_1000);
        drive(6'h00, 26'h0000020, 32'h0000_1100, 32'h0);
        @(posedge clk); #1;
        check("add_hold_r31", register31, 32'h0000_1000);

        // JALR, then asynchronous reset in the middle of a cycle.
        drive(6'h13, 26'h0, 32'h0000_2004, 32'hDEAD_BEE0);
        #1;
        check("jalr_take", {31'b0, takeBranch}, 32'h1);
        check("jalr_pc", outputPC, 32'hDEAD_BEE0);
        @(posedge clk); #1;
        check("jalr_r31", register31, 32'h0000_2004);
        drive(6'h13, 26'h0, 32'h0000_2008, 32'hDEAD_BEE0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_r31", register31, 32'h0000_0000);
        check("reset_no_effect_pc", outputPC, 32'hDEAD_BEE0);
        @(posedge clk); #1;
        check("reset_dominates_jalr", register31, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        drive(6'h00, 26'h0, 32'h0000_2100, 32'h0);

`ifdef JUMP_BRANCH_TRAP_RFE_EN
        @(negedge clk);
        drive(6'h11, 26'h2000000, 32'h0000_0900, 32'h0);
        #1;
        check("trap_zext_pc", outputPC, 32'h0200_0000);
        @(negedge clk);
        drive(6'h11, 26'h0000020, 32'h0000_3000, 32'h0);
        #1;
        check("trap_take", {31'b0, takeBranch}, 32'h1);
        check("trap_pc", outputPC, 32'h0000_0020);
        @(posedge clk); #1;
        drive(6'h10, 26'h0, 32'h0000_4000, 32'h0);
        #1;
        check("rfe_take", {31'b0, takeBranch}, 32'h1);
        check("rfe_pc", outputPC, 32'h0000_3000);
        check("trap_no_link", register31, 32'h0000_0000);
`else
        @(negedge clk);
        drive(6'h11, 26'h0000020, 32'h0000_3000, 32'h0);
        #1;
        check("trap_off_take", {31'b0, takeBranch}, 32'h0);
        check("trap_off_pc", outputPC, 32'h0000_3000);
        @(posedge clk); #1;
        drive(6'h10, 26'h0, 32'h0000_4000, 32'h0);
        #1;
        check("rfe_off_take", {31'b0, takeBranch}, 32'h0);
        check("rfe_off_pc", outputPC, 32'h0000_4000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
